// File: rtl/fifo_ptr_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_ptr_ctrl_if
// Signal bundle between a FIFO user (producer/consumer) and the pointer/flag
// controller.
//
// Handshake: fifo_wr / fifo_rd are requests. They are accepted in exactly the
// cycle where the controller raises push / pop (combinational strobes, same
// cycle). There is no back-pressure or retry. A request seen without its
// strobe is dropped and is not held or queued.
//
// Signals:
//   fifo_wr, fifo_rd, err_clr          requests from the user
//   push, pop                          qualified memory strobes
//   wr_ptr, rd_ptr                     registered memory addresses
//   fifo_count                         registered occupancy (PTR+1 bits)
//   fifo_empty, fifo_full,
//   almost_empty, almost_full          flags decoded from fifo_count
//   err_overflow, err_underflow        sticky error flags
// ----------------------------------------------------------------------------
interface fifo_ptr_ctrl_if #(
    parameter int PTR = 3
);
    logic           fifo_wr;
    logic           fifo_rd;
    logic           err_clr;
    logic           push;
    logic           pop;
    logic [PTR-1:0] wr_ptr;
    logic [PTR-1:0] rd_ptr;
    logic [PTR:0]   fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           almost_empty;
    logic           almost_full;
    logic           err_overflow;
    logic           err_underflow;

    // User side: issues requests and observes status.
    modport master (
        output fifo_wr, fifo_rd, err_clr,
        input  push, pop, wr_ptr, rd_ptr, fifo_count,
        input  fifo_empty, fifo_full, almost_empty, almost_full,
        input  err_overflow, err_underflow
    );

    // Controller side.
    modport slave (
        input  fifo_wr, fifo_rd, err_clr,
        output push, pop, wr_ptr, rd_ptr, fifo_count,
        output fifo_empty, fifo_full, almost_empty, almost_full,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Pointer and flag controller for a synchronous FIFO. It owns the read and
// write pointers, the occupancy counter, the full/empty/almost flags, and the
// sticky overflow/underflow errors. MEM_SIZE need not be a power of two, so
// the pointers wrap explicitly at MEM_SIZE-1.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fifo_ptr_ctrl_if.slave (requests in, strobes/pointers/flags out)
// ----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter int MEM_SIZE  = 8,
    parameter int PTR       = 3,
    parameter int AE_THRESH = 1,
    parameter int AF_THRESH = 7
) (
    input  logic          clk,
    input  logic          reset,
    fifo_ptr_ctrl_if.slave bus
);
    localparam logic [PTR-1:0] LAST_PTR = PTR'(MEM_SIZE - 1);
    localparam logic [PTR:0]   SIZE_CNT = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0]   AE_CNT   = (PTR+1)'(AE_THRESH);
    localparam logic [PTR:0]   AF_CNT   = (PTR+1)'(AF_THRESH);

    logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR:0]   count_q,  count_d;
    logic           ovf_q,    ovf_d;
    logic           unf_q,    unf_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Flags come only from the count register, never from the inputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == SIZE_CNT);

    // No read bypass on empty. A write into a full FIFO is accepted only when
    // a read frees a slot in the same cycle.
    assign pop  = !reset && bus.fifo_rd && !empty;
    assign push = !reset && bus.fifo_wr && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR'(1);
        end

        count_d = count_q + {{PTR{1'b0}}, push} - {{PTR{1'b0}}, pop};

        // Clear first, so a same-cycle error event overrides the clear.
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (bus.fifo_wr && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (bus.fifo_rd && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.push          = push;
    assign bus.pop           = pop;
    assign bus.wr_ptr        = wr_ptr_q;
    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.fifo_count    = count_q;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.almost_empty  = (count_q <= AE_CNT);
    assign bus.almost_full   = (count_q >= AF_CNT);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst6 = 1'b1;
  bit   sel = 1'b0;  // 0: drive/check dut8, 1: drive/check dut6

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int m_wr = 0, m_rd = 0, m_cnt = 0;
  bit m_ovf = 0, m_unf = 0;
  int m_size = 8, m_ae = 1, m_af = 7;

  logic [15:0] exp_q[$];
  logic [15:0] obs8, obs6;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.PTR(3)) b8 ();
  fifo_ptr_ctrl_if #(.PTR(3)) b6 ();

  fifo_ptr_ctrl #(.MEM_SIZE(8), .PTR(3), .AE_THRESH(1), .AF_THRESH(7))
    dut8 (.clk(clk), .reset(rst8), .bus(b8));
  fifo_ptr_ctrl #(.MEM_SIZE(6), .PTR(3), .AE_THRESH(1), .AF_THRESH(5))
    dut6 (.clk(clk), .reset(rst6), .bus(b6));

  assign obs8 = {b8.wr_ptr, b8.rd_ptr, b8.fifo_count, b8.fifo_empty, b8.fifo_full,
                 b8.almost_empty, b8.almost_full, b8.err_overflow, b8.err_underflow};
  assign obs6 = {b6.wr_ptr, b6.rd_ptr, b6.fifo_count, b6.fifo_empty, b6.fifo_full,
                 b6.almost_empty, b6.almost_full, b6.err_overflow, b6.err_underflow};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_pack();
    return {3'(m_wr), 3'(m_rd), 4'(m_cnt), m_cnt == 0, m_cnt == m_size,
            m_cnt <= m_ae, m_cnt >= m_af, m_ovf, m_unf};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit wr, input bit rd, input bit clr, input bit rst);
    bit e_push, e_pop, m_empty, m_full;
    logic o_push, o_pop;
    logic [15:0] exp;
    @(negedge clk);
    if (!sel) begin
      b8.fifo_wr = wr; b8.fifo_rd = rd; b8.err_clr = clr; rst8 = rst;
    end else begin
      b6.fifo_wr = wr; b6.fifo_rd = rd; b6.err_clr = clr; rst6 = rst;
    end
    #1;
    m_empty = (m_cnt == 0);
    m_full  = (m_cnt == m_size);
    e_pop   = !rst && rd && !m_empty;
    e_push  = !rst && wr && (!m_full || e_pop);
    o_push  = sel ? b6.push : b8.push;
    o_pop   = sel ? b6.pop : b8.pop;
    check("push_strobe", {15'b0, o_push}, {15'b0, e_push});
    check("pop_strobe", {15'b0, o_pop}, {15'b0, e_pop});
    if (rst) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (e_push) m_wr = (m_wr == m_size - 1) ? 0 : m_wr + 1;
      if (e_pop)  m_rd = (m_rd == m_size - 1) ? 0 : m_rd + 1;
      m_cnt = m_cnt + int'(e_push) - int'(e_pop);
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (wr && m_full && !e_pop) m_ovf = 1;
      if (rd && m_empty) m_unf = 1;
    end
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("state", sel ? obs6 : obs8, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    b8.fifo_wr = 0; b8.fifo_rd = 0; b8.err_clr = 0;
    b6.fifo_wr = 0; b6.fifo_rd = 0; b6.err_clr = 0;
    @(posedge clk);

    // reset state of the 8-entry instance
    step(0, 0, 0, 1);
    check("reset_empty_flags", {12'b0, b8.fifo_empty, b8.almost_empty, b8.fifo_full, b8.almost_full},
          16'b1100);

    // fill with 8 writes
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0);
      if (i == 6) check("af_at_6", {15'b0, b8.almost_full}, 16'd0);
      if (i == 7) check("af_at_7", {14'b0, b8.almost_full, b8.fifo_full}, 16'b10);
    end
    check("full_state", {b8.wr_ptr, b8.rd_ptr, b8.fifo_count, 6'b0, b8.fifo_full},
          {3'd0, 3'd0, 4'd8, 6'b0, 1'b1});

    // overflow then clear
    step(1, 0, 0, 0);
    check("overflow_set", {11'b0, b8.fifo_count, b8.err_overflow}, {11'b0, 4'd8, 1'b1});
    step(0, 0, 1, 0);
    check("overflow_clr", {15'b0, b8.err_overflow}, 16'd0);

    // simultaneous read/write while full
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    check("full_rw", {b8.wr_ptr, b8.rd_ptr, b8.fifo_count, 4'b0, b8.err_overflow, b8.err_underflow},
          {3'd3, 3'd3, 4'd8, 4'b0, 1'b0, 1'b0});

    // drain, then read+write on empty
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    check("drained", {12'b0, b8.fifo_count}, 16'd0);
    step(1, 1, 0, 0);
    check("empty_rw", {10'b0, b8.fifo_count, b8.fifo_empty, b8.err_underflow},
          {10'b0, 4'd1, 1'b0, 1'b1});

    // fill to 5 then reset with a pending write
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("count_5", {12'b0, b8.fifo_count}, 16'd5);
    step(1, 0, 0, 1);
    check("after_reset", obs8, {3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    // error set wins over a same-cycle clear
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("set_beats_clr", {15'b0, b8.err_underflow}, 16'd1);
    step(0, 0, 1, 0);
    check("unf_cleared", {15'b0, b8.err_underflow}, 16'd0);

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'b0);

    // ---------------- 6-entry instance ----------------
    @(negedge clk);
    b8.fifo_wr = 0; b8.fifo_rd = 0; b8.err_clr = 0; rst8 = 1;
    sel = 1; m_size = 6; m_ae = 1; m_af = 5;
    step(0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      if (b6.wr_ptr >= 3'd6 || b6.rd_ptr >= 3'd6)
        check("ptr_range", {10'b0, b6.wr_ptr, b6.rd_ptr}, 16'd0);
    end
    check("wrap6_end", {6'b0, b6.wr_ptr, b6.rd_ptr, b6.fifo_count}, {6'b0, 3'd1, 3'd1, 4'd0});

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
